// File: rtl/alu_md.sv
// ---------------------------------------------------------------------------
// alu_md: integer ALU with an iterative multiply unit and an optional divide
// unit, using a valid/ready handshake on both the request and result sides.
//
// Single-cycle ops (ADD..SLTU) and undecoded ops finish one cycle after they
// are accepted. Multiply ops take WIDTH+1 cycles using a shift-add loop.
// Divide ops also take WIDTH+1 cycles, using restoring division.
//
// Build option:
//   ALU_MD_DIV_EN  - when defined, the divider is built and DIV/DIVU/REM/REMU
//                    are supported. When undefined, those ops are reported as
//                    illegal and finish in one cycle.
//
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   asynchronous reset, active low
//   in_valid   in   request present
//   in_ready   out  block can accept a request (high only while idle)
//   op[4:0]    in   operation code
//   a, b       in   operands (a = shift source / dividend / multiplicand)
//   flush      in   synchronous abort; returns to idle on the next edge
//   out_valid  out  result present
//   out_ready  in   consumer takes the result
//   result     out  result value
//   zero       out  result == 0
//   illegal    out  op was not a supported operation
// ---------------------------------------------------------------------------
module alu_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_MUL   = 5'd10;
    localparam logic [4:0] OP_MULH  = 5'd11;
    localparam logic [4:0] OP_MULHU = 5'd12;
`ifdef ALU_MD_DIV_EN
    localparam logic [4:0] OP_DIV   = 5'd13;
    localparam logic [4:0] OP_DIVU  = 5'd14;
    localparam logic [4:0] OP_REM   = 5'd15;
    localparam logic [4:0] OP_REMU  = 5'd16;
`endif

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t               state_q;
    logic                 inReady_q;
    logic                 outValid_q;
    logic [WIDTH-1:0]     result_q;
    logic                 zero_q;
    logic                 illegal_q;
    logic [4:0]           op_q;
    logic                 neg_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     count_q;

    logic [SHW-1:0]       shamt;
    logic [WIDTH-1:0]     aluRes_d;
    logic                 isIllegal_d;
    logic                 isIterative_d;
    logic                 isMulOp_d;
    logic                 signedIn;
    logic                 neg_d;
    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;
    logic [WIDTH-1:0]     mcandInit_d;
    logic [2*WIDTH-1:0]   prodInit_d;
    logic [WIDTH:0]       mulSum;
    logic [2*WIDTH-1:0]   prod_d;
    logic [WIDTH-1:0]     prodHi;
    logic [WIDTH-1:0]     prodLo;
    logic [WIDTH-1:0]     mdResult_d;
    logic                 lastIter;
`ifdef ALU_MD_DIV_EN
    logic                 opIsMul;
    logic [WIDTH:0]       divShift;
    logic [WIDTH:0]       divDiff;
`endif

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    // Decode the incoming request: single-cycle results are computed here and
    // captured at accept; iterative ops only need to be flagged.
    always_comb begin
        shamt         = b[SHW-1:0];
        aluRes_d      = '0;
        isIllegal_d   = 1'b0;
        isIterative_d = 1'b0;
        case (op)
            OP_ADD:  aluRes_d = a + b;
            OP_SUB:  aluRes_d = a - b;
            OP_AND:  aluRes_d = a & b;
            OP_OR:   aluRes_d = a | b;
            OP_XOR:  aluRes_d = a ^ b;
            OP_SLL:  aluRes_d = a << shamt;
            OP_SRL:  aluRes_d = a >> shamt;
            OP_SRA:  aluRes_d = $signed(a) >>> shamt;
            OP_SLT:  aluRes_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: aluRes_d = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MUL, OP_MULH, OP_MULHU: isIterative_d = 1'b1;
`ifdef ALU_MD_DIV_EN
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: isIterative_d = 1'b1;
`endif
            default: isIllegal_d = 1'b1;
        endcase
    end

    // Signed ops run on magnitudes; neg_d records whether the final value
    // must be negated. A signed divide by zero keeps the all-ones quotient,
    // so no negation is requested in that case.
    always_comb begin
        isMulOp_d = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
        signedIn  = 1'b0;
        neg_d     = 1'b0;
        case (op)
            OP_MULH: begin
                signedIn = 1'b1;
                neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
            end
`ifdef ALU_MD_DIV_EN
            OP_DIV: begin
                signedIn = 1'b1;
                neg_d    = (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
            end
            OP_REM: begin
                signedIn = 1'b1;
                neg_d    = a[WIDTH-1];
            end
`endif
            default: ;
        endcase
        magA        = (signedIn && a[WIDTH-1]) ? -a : a;
        magB        = (signedIn && b[WIDTH-1]) ? -b : b;
        // Multiply: low half holds the multiplier, mcand the multiplicand.
        // Divide: low half holds the dividend, mcand the divisor.
        mcandInit_d = isMulOp_d ? magA : magB;
        prodInit_d  = {{WIDTH{1'b0}}, (isMulOp_d ? magB : magA)};
    end

    // One iteration of the shared datapath. Multiply adds the multiplicand to
    // the upper half when the low bit is set, then shifts right. Divide shifts
    // the remainder/quotient pair left and keeps the trial subtraction when it
    // does not go negative.
    always_comb begin
        mulSum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
               + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        prod_d = {mulSum, prod_q[WIDTH-1:1]};
`ifdef ALU_MD_DIV_EN
        opIsMul  = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHU);
        divShift = prod_q[2*WIDTH-1:WIDTH-1];
        divDiff  = divShift - {1'b0, mcand_q};
        if (!opIsMul) begin
            if (divDiff[WIDTH]) begin
                prod_d = {divShift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
            end else begin
                prod_d = {divDiff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
            end
        end
`endif
    end

    // Form the final iterative result from the last iteration's value.
    // MULH negates the full double-width product; the upper half of -P is
    // ~P_hi plus the carry out of ~P_lo + 1, which happens only when P_lo is 0.
    always_comb begin
        prodHi     = prod_d[2*WIDTH-1:WIDTH];
        prodLo     = prod_d[WIDTH-1:0];
        lastIter   = (count_q == WIDTH'(WIDTH - 1));
        mdResult_d = '0;
        case (op_q)
            OP_MUL:   mdResult_d = prodLo;
            OP_MULH:  mdResult_d = neg_q ? (~prodHi + {{(WIDTH-1){1'b0}}, (prodLo == '0)})
                                         : prodHi;
            OP_MULHU: mdResult_d = prodHi;
`ifdef ALU_MD_DIV_EN
            OP_DIV, OP_DIVU: mdResult_d = neg_q ? -prodLo : prodLo;
            OP_REM, OP_REMU: mdResult_d = neg_q ? -prodHi : prodHi;
`endif
            default: ;
        endcase
    end

    // Control FSM with registered handshake outputs. Flush wins over accept
    // and over out_ready, and it discards whatever was in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            illegal_q  <= 1'b0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            prod_q     <= '0;
            mcand_q    <= '0;
            count_q    <= '0;
        end else if (flush) begin
            state_q    <= IDLE;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q      <= op;
                        neg_q     <= neg_d;
                        count_q   <= '0;
                        inReady_q <= 1'b0;
                        if (isIterative_d) begin
                            prod_q  <= prodInit_d;
                            mcand_q <= mcandInit_d;
                            state_q <= BUSY;
                        end else begin
                            result_q   <= aluRes_d;
                            zero_q     <= (aluRes_d == '0);
                            illegal_q  <= isIllegal_d;
                            outValid_q <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                BUSY: begin
                    prod_q  <= prod_d;
                    count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    if (lastIter) begin
                        result_q   <= mdResult_d;
                        zero_q     <= (mdResult_d == '0);
                        illegal_q  <= 1'b0;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    inReady_q  <= 1'b1;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; legal values are even and at least 8.
REQ-002 SHALL have port clk input 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn input 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid input 1: request present.
REQ-005 SHALL have port in_ready output 1: block can accept a request.
REQ-006 SHALL have port op input 5: operation code per REQ-012.
REQ-007 SHALL have ports a, b input WIDTH each: operands (a is shift source, dividend and multiplicand).
REQ-008 SHALL have port flush input 1: synchronous abort of any operation in flight.
REQ-009 SHALL have port out_valid output 1: result present.
REQ-010 SHALL have port out_ready input 1: consumer accepts result.
REQ-011 SHALL have ports result output WIDTH, zero output 1 (result == 0), and illegal output 1 (unsupported op); all are valid only while out_valid is high.

Function
REQ-012 SHALL decode op as: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL (low half), 11 MULH (signed x signed, high half), 12 MULHU (unsigned, high half), 13 DIV, 14 DIVU, 15 REM, 16 REMU; any other value is illegal.
REQ-013 SHALL take shift amounts from b[log2(WIDTH)-1:0] only, and SHALL produce SLT/SLTU results as zero-extended 0/1.
REQ-014 SHALL implement FSM IDLE -> (accept, single-cycle or illegal op) -> DONE; IDLE -> (accept, op 10-16) -> BUSY; BUSY -> (iteration counter reaches WIDTH) -> DONE; DONE -> (out_ready) -> IDLE.
REQ-015 SHALL drive in_ready high exactly in IDLE; accept occurs on a cycle with in_valid and in_ready both high, and op, a and b are registered at accept.
REQ-016 SHALL assert out_valid in DONE only, with latency from accept edge to out_valid high of 1 cycle for ops 0-9 and illegal ops, and WIDTH+1 cycles for ops 10-16.
REQ-017 SHALL hold result, zero and illegal stable while out_valid is high and out_ready is low, and SHALL ignore in_valid outside IDLE.
REQ-018 SHALL compute multiply by a radix-2 shift-add over a 2*WIDTH product, one bit per cycle, with a WIDTH-bit iteration counter.
REQ-019 SHALL compute divide by restoring division, one quotient bit per cycle, on magnitudes, and SHALL sign-correct for signed ops (quotient negated when signs differ; remainder takes the dividend's sign).
REQ-020 SHALL handle divide by zero as quotient all-ones and remainder = a, for both signed and unsigned forms.
REQ-021 SHALL handle signed overflow (a = most negative, b = -1) as DIV quotient = a and REM remainder = 0.
REQ-022 SHALL treat flush high as forcing IDLE on the next edge from any state, dropping out_valid and discarding any partial result.
REQ-023 SHALL give flush priority over a simultaneous accept (the request is not taken) and over a simultaneous out_ready.
REQ-024 SHALL drive illegal = 1 and result = 0 for an undecoded op.

Reset
REQ-025 SHALL, while rstn is low, force IDLE, in_ready = 1, out_valid = 0, result = 0, zero = 1, illegal = 0, and clear all counters and operand/partial registers.
REQ-026 SHALL treat reset asserted mid-operation as abandoning the operation with no output; the first accept after release behaves as from power-up.

Configuration
REQ-027 SHALL, when macro ALU_MD_DIV_EN is defined, include the divider and support ops 13-16 per REQ-019..REQ-021.
REQ-028 SHALL, when ALU_MD_DIV_EN is undefined, omit the divider logic entirely and treat ops 13-16 as illegal per REQ-024 with 1-cycle latency; multiply ops are unaffected.

Verification
REQ-029 SHALL cover: WIDTH=32, ADD a=0x7FFFFFFF b=1 -> result 0x80000000, zero 0, out_valid exactly 1 cycle after accept; SUB a=5 b=5 -> result 0, zero 1.
REQ-030 SHALL cover: SRA a=0x80000000 b=0x24 (shift 4) -> 0xF8000000; SLTU a=1 b=0xFFFFFFFF -> 1; SLT with the same operands -> 0.
REQ-031 SHALL cover: MULH a=0xFFFFFFFF b=0xFFFFFFFF -> 0, MULHU with the same operands -> 0xFFFFFFFE, MUL -> 1; out_valid 33 cycles after accept; in_ready low throughout.
REQ-032 SHALL cover: DIV a=-7 b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=7 b=0 -> 0xFFFFFFFF; REMU -> 7; DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-033 SHALL cover: out_ready held low 5 cycles in DONE -> result stable and in_valid ignored; flush asserted in BUSY cycle 10 together with in_valid -> IDLE next cycle, out_valid never asserted, request not taken.
REQ-034 SHALL cover: with ALU_MD_DIV_EN undefined, op 13 -> illegal 1, result 0, 1-cycle latency; op 31 -> illegal 1 in both builds; rstn pulsed low in BUSY -> REQ-025 values immediately, without waiting for a clock edge.
